// File: rtl/dsp_mac_pkg.sv
// Shared constants and the saturation helper for the Q2.14 signed multiply-accumulate.
// Saturation is only used when the DSP_MAC_SAT_EN build macro is defined.
package dsp_mac_pkg;

  localparam int D_W       = 16;
  localparam int FRAC_BITS = 14;
  // Width of the shifted sum: (2*D_W + 1) - FRAC_BITS.
  localparam int R_W       = 2 * D_W + 1 - FRAC_BITS;

  localparam logic [D_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [D_W-1:0] SAT_MIN = 16'h8000;

  localparam logic signed [R_W-1:0] R_HI = R_W'(32767);
  localparam logic signed [R_W-1:0] R_LO = R_W'(-32768);

  // Clamp the wide shifted result into the 16-bit Q2.14 range.
  function automatic logic [D_W-1:0] sat16(input logic signed [R_W-1:0] r);
    if (r > R_HI)      return SAT_MAX;
    else if (r < R_LO) return SAT_MIN;
    else               return r[D_W-1:0];
  endfunction

endpackage

// File: rtl/dsp_16x16_fix14_signed_mac.sv
// Signed 16x16 MAC: out = (A*B + {C,D}) >>> 14, combinational when dsp_CE=1, held otherwise.
// Build macro DSP_MAC_SAT_EN selects saturation instead of two's-complement wrap.
module dsp_16x16_fix14_signed_mac
  import dsp_mac_pkg::*;
(
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  dsp_CE,
  input  logic signed [D_W-1:0] dsp_A,
  input  logic signed [D_W-1:0] dsp_B,
  input  logic        [D_W-1:0] dsp_C,
  input  logic        [D_W-1:0] dsp_D,
  output logic        [D_W-1:0] fix_14_16_Out
);

  logic signed [2*D_W-1:0] prod;
  logic        [2*D_W-1:0] addend;
  logic signed [2*D_W:0]   sum;
  logic signed [R_W-1:0]   res;
  logic        [D_W-1:0]   live;
  logic        [D_W-1:0]   hold_q;

  // Plain behavioural multiply/add so synthesis maps it onto the hard MAC.
  assign prod   = dsp_A * dsp_B;
  assign addend = {dsp_C, dsp_D};
  // One extra bit of headroom: the largest product plus the largest addend cannot wrap.
  assign sum    = {prod[2*D_W-1], prod} + {addend[2*D_W-1], addend};
  // Dropping the fraction bits of a two's-complement sum is an arithmetic shift (floor).
  assign res    = sum[2*D_W:FRAC_BITS];

`ifdef DSP_MAC_SAT_EN
  assign live = sat16(res);

  logic unused_bits;
  assign unused_bits = ^sum[FRAC_BITS-1:0];
`else
  assign live = res[D_W-1:0];

  logic unused_bits;
  assign unused_bits = ^{sum[FRAC_BITS-1:0], res[R_W-1:D_W]};
`endif

  // NOTE: sequential state uses non-blocking assignments so every reader sees the pre-edge value.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)     hold_q <= '0;
    else if (dsp_CE) hold_q <= live;
  end

  assign fix_14_16_Out = dsp_CE ? live : hold_q;

endmodule

// File: tb/tb_dsp_16x16_fix14_signed_mac.sv
// Scoreboard bench for dsp_16x16_fix14_signed_mac with hand-computed vectors.
// Expected values follow the DSP_MAC_SAT_EN build macro when it is defined.
module tb_dsp_16x16_fix14_signed_mac;

  typedef struct {
    logic [15:0] exp;
    string       name;
  } exp_t;

`ifdef DSP_MAC_SAT_EN
  localparam logic [15:0] EXP_MINSQ  = 16'h7FFF;
  localparam logic [15:0] EXP_MINMAX = 16'h8000;
  localparam logic [15:0] EXP_MAXSQ  = 16'h7FFF;
`else
  localparam logic [15:0] EXP_MINSQ  = 16'h0000;
  localparam logic [15:0] EXP_MINMAX = 16'h0002;
  localparam logic [15:0] EXP_MAXSQ  = 16'hFFFC;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        dsp_CE  = 1'b0;
  logic [15:0] dsp_A   = '0;
  logic [15:0] dsp_B   = '0;
  logic [15:0] dsp_C   = '0;
  logic [15:0] dsp_D   = '0;
  logic [15:0] fix_14_16_Out;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 sys_clk = ~sys_clk;

  dsp_16x16_fix14_signed_mac dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .dsp_CE        (dsp_CE),
    .dsp_A         (dsp_A),
    .dsp_B         (dsp_B),
    .dsp_C         (dsp_C),
    .dsp_D         (dsp_D),
    .fix_14_16_Out (fix_14_16_Out)
  );

  // Drive one vector just after a rising edge and queue what the output must show this cycle.
  task automatic apply(input logic rst, input logic ce,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d,
                       input logic [15:0] exp, input string name);
    exp_t e;
    @(posedge sys_clk);
    #1;
    sys_rst = rst;
    dsp_CE  = ce;
    dsp_A   = a;
    dsp_B   = b;
    dsp_C   = c;
    dsp_D   = d;
    e.exp   = exp;
    e.name  = name;
    exp_q.push_back(e);
  endtask

  // Monitor: the output is presented every cycle, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (fix_14_16_Out !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, fix_14_16_Out, e.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //     rst   ce    A        B        C        D        expected    name
    apply(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, "reset_state");
    apply(1'b0, 1'b1, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h4000, "one_x_one");
    apply(1'b0, 1'b1, 16'hC000, 16'h2000, 16'h0000, 16'h0000, 16'hE000, "neg_one_x_half");
    apply(1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'hC000, 16'h0003, "addend_only");
    apply(1'b0, 1'b1, 16'h4000, 16'h0005, 16'h0000, 16'hC000, 16'h0008, "prod_plus_addend");
    apply(1'b0, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF, "floor_neg_lsb");
    apply(1'b0, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 16'hC000, 16'hFFFF, "neg_addend");
    apply(1'b0, 1'b1, 16'h8000, 16'h8000, 16'h0000, 16'h0000, EXP_MINSQ,  "min_squared");
    apply(1'b0, 1'b1, 16'h8000, 16'h7FFF, 16'hC000, 16'h0000, EXP_MINMAX, "min_max_neg_add");
    apply(1'b0, 1'b1, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, EXP_MAXSQ,  "max_squared");
    // Hold behaviour
    apply(1'b0, 1'b1, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h4000, "hold_load");
    apply(1'b0, 1'b0, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h4000, "hold_ce_low");
    apply(1'b0, 1'b0, 16'h1234, 16'h4000, 16'h0000, 16'h0000, 16'h4000, "hold_after_edge");
    apply(1'b0, 1'b1, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, "hold_release");
    // Reset while held
    apply(1'b0, 1'b1, 16'hC000, 16'h2000, 16'h0000, 16'h0000, 16'hE000, "rst_preload");
    apply(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hE000, "rst_before_edge");
    apply(1'b0, 1'b0, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, "rst_clears_hold");
    apply(1'b0, 1'b1, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h4000, "live_restored");
    // Reset takes priority over CE at the edge, while CE=1 keeps the output live
    apply(1'b1, 1'b1, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h4000, "rst_ce_live");
    apply(1'b0, 1'b0, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, "rst_over_ce");

    repeat (3) @(posedge sys_clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
